// File: rtl/song_sequencer.sv
// Song sequencer: steps through a song ROM and issues one note at a time to the note player.
// Stops at a zero-duration terminator or after index 31.
module song_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        reset_play,
  input  logic        play,
  input  logic [1:0]  song,
  input  logic        note_done,
  output logic [6:0]  rom_addr,
  input  logic [11:0] rom_data,
  output logic        new_note,
  output logic [5:0]  note,
  output logic [5:0]  duration,
  output logic        song_done
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitRom,
    StIssue,
    StWaitNote,
    StEnd
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  index_q, index_d;
  logic [5:0]  note_q, note_d;
  logic [5:0]  duration_q, duration_d;
  logic        new_note_q, new_note_d;
  logic        song_done_q, song_done_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    note_d     = note_q;
    duration_d = duration_q;
    unique case (state_q)
      StIdle: begin
        if (play) state_d = StFetch;
      end
      StFetch: state_d = StWaitRom;
      StWaitRom: begin
        // A zero duration marks the end of the song; keep the last note visible.
        if (rom_data[5:0] == 6'd0) begin
          state_d = StEnd;
        end else begin
          note_d     = rom_data[11:6];
          duration_d = rom_data[5:0];
          state_d    = StIssue;
        end
      end
      StIssue: state_d = StWaitNote;
      StWaitNote: begin
        if (note_done) begin
          if (index_q == 5'd31) begin
            state_d = StEnd;
          end else begin
            index_d = index_q + 5'd1;
            state_d = play ? StFetch : StIdle;
          end
        end
      end
      StEnd: begin
        index_d = 5'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (reset_play) begin
      state_d    = StIdle;
      index_d    = 5'd0;
      note_d     = 6'd0;
      duration_d = 6'd0;
    end
  end

  // Pulses are registered, so each lands one cycle after its state is left.
  always_comb begin
    new_note_d  = (state_q == StIssue) && !reset_play;
    song_done_d = (state_q == StEnd) && !reset_play;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_q     <= 5'd0;
      note_q      <= 6'd0;
      duration_q  <= 6'd0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      index_q     <= index_d;
      note_q      <= note_d;
      duration_q  <= duration_d;
      new_note_q  <= new_note_d;
      song_done_q <= song_done_d;
    end
  end

  assign rom_addr  = {song, index_q};
  assign new_note  = new_note_q;
  assign note      = note_q;
  assign duration  = duration_q;
  assign song_done = song_done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: synchronous ROM model, note scoreboard,
// table-driven full song plus hand-written pause, restart and async-reset sequences.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset_play;
  logic        play;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        song_done;

  song_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .reset_play (reset_play),
    .play       (play),
    .song       (song),
    .note_done  (note_done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .new_note   (new_note),
    .note       (note),
    .duration   (duration),
    .song_done  (song_done)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [128];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [5:0] n;
    logic [5:0] d;
  } exp_t;

  typedef struct {
    logic [11:0] word;
    logic [5:0]  exp_note;
    logic [5:0]  exp_dur;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[32];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_new    = 0;
  int   n_done   = 0;
  int   c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every new_note pops the note the stimulus expected next.
  always @(negedge clk) begin
    if (new_note || song_done) check("pulse_exclusive", {31'b0, new_note & song_done}, 0);
    if (song_done) n_done++;
    if (new_note) begin
      n_new++;
      if (sb.size() == 0) begin
        check("unexpected_new_note", {31'b0, new_note}, 0);
      end else begin
        mon_e = sb.pop_front();
        check("note", {26'b0, note}, {26'b0, mon_e.n});
        check("duration", {26'b0, duration}, {26'b0, mon_e.d});
      end
    end
  end

  // Count negedges until new_note is seen; note_done is dropped after one edge.
  task automatic step_wait(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      note_done = 1'b0;
      cnt++;
    end while (!new_note && cnt < 40);
  endtask

  task automatic wait_song_done(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      note_done = 1'b0;
      cnt++;
    end while (!song_done && cnt < 40);
  endtask

  initial begin
    reset      = 1'b0;
    reset_play = 1'b0;
    play       = 1'b0;
    note_done  = 1'b0;
    song       = 2'd0;

    for (int i = 0; i < 32; i++) begin
      vecs[i].exp_note = 6'(i + 3);
      vecs[i].exp_dur  = 6'(63 - i);
      vecs[i].word     = {vecs[i].exp_note, vecs[i].exp_dur};
    end
    for (int i = 0; i < 128; i++) rom[i] = 12'hfff;
    rom[0] = 12'h041;
    rom[1] = 12'h082;
    rom[2] = 12'h000;
    for (int i = 0; i < 32; i++) rom[32 + i] = vecs[i].word;
    for (int i = 0; i < 32; i++) rom[64 + i] = {6'(10 + i), 6'(i + 1)};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_new_note", {31'b0, new_note}, 0);
    check("rst_song_done", {31'b0, song_done}, 0);
    check("rst_note", {26'b0, note}, 0);
    check("rst_duration", {26'b0, duration}, 0);
    check("rst_rom_addr", {25'b0, rom_addr}, 0);

    // Two notes then terminator on song 0
    reset = 1'b1;
    play  = 1'b1;
    sb.push_back('{n: 6'd1, d: 6'd1});
    step_wait(c);
    check("lat_first", c, 4);
    @(negedge clk);
    check("new_note_one_cycle", {31'b0, new_note}, 0);
    sb.push_back('{n: 6'd2, d: 6'd2});
    note_done = 1'b1;
    step_wait(c);
    check("lat_second", c, 4);
    note_done = 1'b1;
    wait_song_done(c);
    check("term_song_done_lat", c, 4);
    play = 1'b0;
    check("term_index_zero", {25'b0, rom_addr}, 0);
    check("term_note_held", {26'b0, note}, 2);
    check("term_dur_held", {26'b0, duration}, 2);
    repeat (6) @(negedge clk);
    check("term_song_done_count", n_done, 1);
    check("term_new_note_count", n_new, 2);

    // Full 32-note song on song 1
    song = 2'd1;
    play = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sb.push_back('{n: vecs[i].exp_note, d: vecs[i].exp_dur});
      if (i > 0) note_done = 1'b1;
      step_wait(c);
      check("lat_full", c, 4);
    end
    note_done = 1'b1;
    wait_song_done(c);
    check("full_song_done_lat", c, 2);
    play = 1'b0;
    repeat (4) @(negedge clk);
    check("full_new_note_count", n_new, 34);
    check("full_song_done_count", n_done, 2);
    check("full_index_zero", {25'b0, rom_addr}, {25'b0, 2'd1, 5'd0});

    // Pause at index 4, resume at index 5 (song 2)
    song = 2'd2;
    play = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{n: 6'(10 + i), d: 6'(i + 1)});
      if (i > 0) note_done = 1'b1;
      step_wait(c);
      check("lat_pause_run", c, 4);
    end
    play      = 1'b0;
    note_done = 1'b1;
    @(negedge clk);
    note_done = 1'b0;
    repeat (5) @(negedge clk);
    check("pause_addr", {25'b0, rom_addr}, {25'b0, 2'd2, 5'd5});
    check("pause_no_note", n_new, 39);
    sb.push_back('{n: 6'd15, d: 6'd6});
    play = 1'b1;
    step_wait(c);
    check("resume_lat", c, 4);

    // reset_play with note_done in WAIT_NOTE
    reset_play = 1'b1;
    note_done  = 1'b1;
    @(negedge clk);
    reset_play = 1'b0;
    note_done  = 1'b0;
    play       = 1'b0;
    check("rp_note", {26'b0, note}, 0);
    check("rp_duration", {26'b0, duration}, 0);
    check("rp_new_note", {31'b0, new_note}, 0);
    check("rp_rom_addr", {25'b0, rom_addr}, {25'b0, 2'd2, 5'd0});
    repeat (4) @(negedge clk);
    check("rp_no_song_done", n_done, 2);
    check("rp_no_new_note", n_new, 40);

    // Async reset mid-WAIT_ROM
    play = 1'b1;
    sb.push_back('{n: 6'd10, d: 6'd1});
    step_wait(c);
    check("ar_first_lat", c, 4);
    note_done = 1'b1;
    @(negedge clk);
    note_done = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("ar_note", {26'b0, note}, 0);
    check("ar_duration", {26'b0, duration}, 0);
    check("ar_new_note", {31'b0, new_note}, 0);
    check("ar_song_done", {31'b0, song_done}, 0);
    check("ar_rom_addr", {25'b0, rom_addr}, {25'b0, 2'd2, 5'd0});
    play = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("ar_no_new_note", n_new, 41);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL provide: clk  input  1  rising-edge system clock.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: reset_play  input  1  synchronous restart request from the player controller; active high.
REQ-004 SHALL provide: play  input  1  level; high = playback enabled, low = paused.
REQ-005 SHALL provide: song  input  2  selected song number.
REQ-006 SHALL provide: note_done  input  1  one-cycle pulse from the note player when the current note ends.
REQ-007 SHALL provide: rom_addr  output  7  song ROM address, always {song, index[4:0]}.
REQ-008 SHALL provide: rom_data  input  12  ROM word; [11:6] = note code, [5:0] = duration; valid one cycle after the address.
REQ-009 SHALL provide: new_note  output  1  one-cycle pulse; note and duration are valid.
REQ-010 SHALL provide: note  output  6  current note code.
REQ-011 SHALL provide: duration  output  6  current note duration.
REQ-012 SHALL provide: song_done  output  1  one-cycle pulse at end of song.

Function
REQ-013 SHALL implement the FSM states IDLE, FETCH, WAIT_ROM, ISSUE, WAIT_NOTE and END, with a 5-bit note index.
REQ-014 IDLE SHALL go to FETCH when play=1 and SHALL otherwise stay in IDLE.
REQ-015 FETCH SHALL present rom_addr for one cycle, then go to WAIT_ROM.
REQ-016 WAIT_ROM SHALL go to END when rom_data[5:0]=0, leaving note and duration unchanged.
REQ-017 Otherwise, WAIT_ROM SHALL register note and duration from rom_data and go to ISSUE.
REQ-018 ISSUE SHALL assert new_note for exactly one cycle, then go to WAIT_NOTE.
REQ-019 WAIT_NOTE SHALL hold until note_done=1.
REQ-020 On note_done, if index=31, WAIT_NOTE SHALL go to END.
REQ-021 On note_done, if index<31, WAIT_NOTE SHALL increment index, then go to FETCH if play=1, else to IDLE (pause; resume at the new index).
REQ-022 END SHALL assert song_done for exactly one cycle, clear index to 0 and go to IDLE.
REQ-023 Latency: play sampled high in IDLE at edge N SHALL give new_note=1 in the cycle following edge N+3.
REQ-024 play falling during FETCH, WAIT_ROM, ISSUE or WAIT_NOTE SHALL NOT abort the current note; the pause SHALL take effect only at note_done.
REQ-025 note_done in any state other than WAIT_NOTE SHALL be ignored.
REQ-026 song SHALL only matter when rom_addr is sampled; a song change without reset_play SHALL continue at the current index of the new song.
REQ-027 note and duration SHALL hold their last values until the next capture in WAIT_ROM.
REQ-028 new_note and song_done SHALL never be high in the same cycle.

Reset
REQ-029 reset=0 SHALL immediately force state=IDLE, index=0, note=0, duration=0, new_note=0 and song_done=0, independent of clk.
REQ-030 reset_play=1 at a clock edge SHALL produce the same register values as REQ-029, without asserting song_done.
REQ-031 reset_play SHALL take priority over note_done, play and END in the same cycle.

Verification
REQ-032 Reset release, play=1 from cycle 0, ROM words 0x041, 0x082 at indices 0 and 1 -> new_note at cycle 3 with note=1/duration=1; after note_done, new_note at +3 with note=2/duration=2.
REQ-033 Terminator: index 2 holds 0x000 -> after the second note_done, song_done pulses once, index returns to 0, and there is no third new_note.
REQ-034 Full song: 32 non-zero words -> 32 new_note pulses, then song_done on the note_done for index 31.
REQ-035 Pause: play=0 during WAIT_NOTE at index 4 -> IDLE after note_done; play=1 later -> rom_addr={song,5}, and the next new_note follows 3 edges later.
REQ-036 reset_play asserted in WAIT_NOTE together with note_done -> IDLE, index=0, no song_done, outputs cleared.
REQ-037 Asynchronous reset driven low mid-WAIT_ROM, between clock edges -> outputs clear immediately, and no new_note follows.
